// File: rtl/power_domain_seq_pkg.sv
// Shared types for the power-domain sequencer: FSM state encoding and the
// per-state drive levels of the domain control outputs.
package power_domain_seq_pkg;

    typedef enum logic [3:0] {
        S_ON      = 4'd0,
        S_OFF_CLK = 4'd1,
        S_OFF_ISO = 4'd2,
        S_OFF_RST = 4'd3,
        S_OFF_SW  = 4'd4,
        S_OFF     = 4'd5,
        S_ON_SW   = 4'd6,
        S_ON_RST  = 4'd7,
        S_ON_ISO  = 4'd8,
        S_ON_CLK  = 4'd9
    } pds_state_e;

    typedef struct packed {
        logic switch_n;
        logic clkgate_en;
        logic iso_n;
        logic rst_n;
    } pds_out_t;

    function automatic pds_out_t pds_state_out(input pds_state_e s);
        pds_out_t o;
        case (s)
            S_ON:      o = '{switch_n: 1'b0, clkgate_en: 1'b1, iso_n: 1'b1, rst_n: 1'b1};
            S_OFF_CLK: o = '{switch_n: 1'b0, clkgate_en: 1'b0, iso_n: 1'b1, rst_n: 1'b1};
            S_OFF_ISO: o = '{switch_n: 1'b0, clkgate_en: 1'b0, iso_n: 1'b0, rst_n: 1'b1};
            S_OFF_RST: o = '{switch_n: 1'b0, clkgate_en: 1'b0, iso_n: 1'b0, rst_n: 1'b0};
            S_OFF_SW:  o = '{switch_n: 1'b1, clkgate_en: 1'b0, iso_n: 1'b0, rst_n: 1'b0};
            S_OFF:     o = '{switch_n: 1'b1, clkgate_en: 1'b0, iso_n: 1'b0, rst_n: 1'b0};
            S_ON_SW:   o = '{switch_n: 1'b0, clkgate_en: 1'b0, iso_n: 1'b0, rst_n: 1'b0};
            S_ON_RST:  o = '{switch_n: 1'b0, clkgate_en: 1'b0, iso_n: 1'b0, rst_n: 1'b1};
            S_ON_ISO:  o = '{switch_n: 1'b0, clkgate_en: 1'b0, iso_n: 1'b1, rst_n: 1'b1};
            S_ON_CLK:  o = '{switch_n: 1'b0, clkgate_en: 1'b1, iso_n: 1'b1, rst_n: 1'b1};
            default:   o = '{switch_n: 1'b0, clkgate_en: 1'b1, iso_n: 1'b1, rst_n: 1'b1};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pds_ack_sync.sv
// Two-flop synchronizer bringing the power-switch acknowledge into clk_i.
module pds_ack_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/power_domain_sequencer.sv
// Power-switch handshake initiator for one gated domain: steps clock gate,
// isolation, reset and switch in order, with acknowledge timeout reporting.
module power_domain_sequencer
    import power_domain_seq_pkg::*;
#(
    parameter int STEP_CYCLES = 4,
    parameter int ACK_TIMEOUT = 64,
    parameter int CNT_W       = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic power_off_req_i,
    input  logic power_on_req_i,
    output logic switch_n_o,
    input  logic switch_ack_n_i,
    output logic clkgate_en_o,
    output logic iso_n_o,
    output logic rst_n_o,
    output logic busy_o,
    output logic domain_on_o,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    pds_state_e       r_state;
    pds_state_e       w_next;
    logic [CNT_W-1:0] r_cnt;
    pds_out_t         r_out;
    logic             r_busy;
    logic             r_domain_on;
    logic             r_timeout;
    logic             w_ack_s;
    logic             w_accept;
    logic             w_timed;
    logic             w_sw_wait;
    logic             w_step_done;
    logic             w_past_entry;

    pds_ack_sync u_ack_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (switch_ack_n_i),
        .q_o   (w_ack_s)
    );

    assign w_timed      = r_state inside {S_OFF_CLK, S_OFF_ISO, S_OFF_RST,
                                          S_ON_RST, S_ON_ISO, S_ON_CLK};
    assign w_sw_wait    = r_state inside {S_OFF_SW, S_ON_SW};
    assign w_step_done  = (r_cnt == STEP_LAST);
    // The synchronizer still shows the old ack level on the entry cycle.
    assign w_past_entry = (r_cnt != '0);

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_ON: begin
                if (power_off_req_i) begin
                    w_next   = S_OFF_CLK;
                    w_accept = 1'b1;
                end
            end
            S_OFF_CLK: if (w_step_done) w_next = S_OFF_ISO;
            S_OFF_ISO: if (w_step_done) w_next = S_OFF_RST;
            S_OFF_RST: if (w_step_done) w_next = S_OFF_SW;
            S_OFF_SW:  if (w_ack_s && w_past_entry) w_next = S_OFF;
            S_OFF: begin
                if (power_on_req_i) begin
                    w_next   = S_ON_SW;
                    w_accept = 1'b1;
                end
            end
            S_ON_SW:   if (!w_ack_s && w_past_entry) w_next = S_ON_RST;
            S_ON_RST:  if (w_step_done) w_next = S_ON_ISO;
            S_ON_ISO:  if (w_step_done) w_next = S_ON_CLK;
            S_ON_CLK:  if (w_step_done) w_next = S_ON;
            default:   w_next = S_ON;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_ON;
        end else begin
            r_state <= w_next;
        end
    end

    // Counter restarts on every state change; saturates while awaiting ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (w_timed || (w_sw_wait && r_cnt != ACK_LAST)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timeout <= 1'b0;
        end else if (w_accept) begin
            r_timeout <= 1'b0;
        end else if (w_sw_wait && r_cnt == ACK_LAST && w_next == r_state) begin
            r_timeout <= 1'b1;
        end
    end

    // Outputs are registered from the next state so they switch on entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out       <= pds_state_out(S_ON);
            r_busy      <= 1'b0;
            r_domain_on <= 1'b1;
        end else begin
            r_out       <= pds_state_out(w_next);
            r_busy      <= !(w_next inside {S_ON, S_OFF});
            r_domain_on <= (w_next == S_ON);
        end
    end

    assign switch_n_o   = r_out.switch_n;
    assign clkgate_en_o = r_out.clkgate_en;
    assign iso_n_o      = r_out.iso_n;
    assign rst_n_o      = r_out.rst_n;
    assign busy_o       = r_busy;
    assign domain_on_o  = r_domain_on;
    assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Directed bench for power_domain_sequencer with a switch-cell responder
// whose acknowledge is direct, delayed by 15 cycles, or tied low.
module tb_power_domain_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        off_req = 1'b0;
    logic        on_req = 1'b0;
    logic        sw_n;
    logic        ack_n;
    logic        cg_en;
    logic        iso_n;
    logic        drst_n;
    logic        busy;
    logic        dom_on;
    logic        tmo;
    logic [14:0] hist = '0;
    int          ack_mode = 1;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) hist <= {hist[13:0], sw_n};

    assign ack_n = (ack_mode == 0) ? sw_n :
                   (ack_mode == 1) ? hist[14] : 1'b0;

    power_domain_sequencer #(
        .STEP_CYCLES (4),
        .ACK_TIMEOUT (64),
        .CNT_W       (8)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .power_off_req_i (off_req),
        .power_on_req_i  (on_req),
        .switch_n_o      (sw_n),
        .switch_ack_n_i  (ack_n),
        .clkgate_en_o    (cg_en),
        .iso_n_o         (iso_n),
        .rst_n_o         (drst_n),
        .busy_o          (busy),
        .domain_on_o     (dom_on),
        .timeout_o       (tmo)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_sw, input logic e_cg,
                           input logic e_iso, input logic e_rst, input logic e_busy,
                           input logic e_on, input logic e_tmo);
        chk({tag, ".switch_n"}, sw_n, e_sw);
        chk({tag, ".clkgate_en"}, cg_en, e_cg);
        chk({tag, ".iso_n"}, iso_n, e_iso);
        chk({tag, ".rst_n"}, drst_n, e_rst);
        chk({tag, ".busy"}, busy, e_busy);
        chk({tag, ".domain_on"}, dom_on, e_on);
        chk({tag, ".timeout"}, tmo, e_tmo);
    endtask

    task automatic pulse(input logic do_off, input logic do_on);
        off_req = do_off;
        on_req  = do_on;
        tick(1);
        off_req = 1'b0;
        on_req  = 1'b0;
    endtask

    initial begin
        // Reset
        #2 rst = 1'b1;
        #2 chk_all("reset", 0, 1, 1, 1, 0, 1, 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        chk_all("post_reset", 0, 1, 1, 1, 0, 1, 0);

        // On request while already ON is dropped
        pulse(0, 1);
        chk_all("on_in_on", 0, 1, 1, 1, 0, 1, 0);
        tick(2);
        chk_all("on_in_on_later", 0, 1, 1, 1, 0, 1, 0);

        // Power-off with 15-cycle responder
        pulse(1, 0);
        chk_all("off_clk", 0, 0, 1, 1, 1, 0, 0);
        tick(3); chk("iso_hold", iso_n, 1'b1);
        tick(1); chk("iso_drop", iso_n, 1'b0);
        tick(3); chk("rst_hold", drst_n, 1'b1);
        tick(1); chk("rst_drop", drst_n, 1'b0);
        tick(3); chk("sw_hold", sw_n, 1'b0);
        tick(1); chk_all("off_sw", 1, 0, 0, 0, 1, 0, 0);
        tick(17); chk("off_sw_wait", busy, 1'b1);
        tick(1); chk_all("off", 1, 0, 0, 0, 0, 0, 0);

        // Power-on with 15-cycle responder
        pulse(0, 1);
        chk_all("on_sw", 0, 0, 0, 0, 1, 0, 0);
        tick(17); chk("on_sw_wait", drst_n, 1'b0);
        tick(1); chk("on_rst", drst_n, 1'b1); chk("on_rst_iso", iso_n, 1'b0);
        tick(3); chk("on_iso_hold", iso_n, 1'b0);
        tick(1); chk("on_iso", iso_n, 1'b1); chk("on_iso_cg", cg_en, 1'b0);
        tick(3); chk("on_cg_hold", cg_en, 1'b0);
        tick(1); chk("on_cg", cg_en, 1'b1); chk("on_cg_dom", dom_on, 1'b0);
        tick(3); chk("on_dom_hold", dom_on, 1'b0);
        tick(1); chk_all("on_done", 0, 1, 1, 1, 0, 1, 0);

        // Off request during OFF_ISO is dropped
        pulse(1, 0);
        tick(5); chk("drop_in_iso", iso_n, 1'b0);
        pulse(1, 0);
        chk("drop_rst_hold", drst_n, 1'b1);
        tick(1); chk("drop_rst_hold2", drst_n, 1'b1);
        tick(1); chk("drop_rst", drst_n, 1'b0);
        tick(4); chk("drop_sw", sw_n, 1'b1);
        tick(18); chk_all("drop_off", 1, 0, 0, 0, 0, 0, 0);
        pulse(0, 1);
        tick(30); chk_all("drop_back_on", 0, 1, 1, 1, 0, 1, 0);

        // Both pulses in ON start power-off; ack tied low forces timeout
        ack_mode = 2;
        pulse(1, 1);
        chk_all("both_off_clk", 0, 0, 1, 1, 1, 0, 0);
        tick(12); chk("tmo_sw", sw_n, 1'b1);
        tick(63); chk("tmo_not_yet", tmo, 1'b0); chk("tmo_busy", busy, 1'b1);
        tick(1); chk_all("tmo_set", 1, 0, 0, 0, 1, 0, 1);
        tick(10); chk_all("tmo_waiting", 1, 0, 0, 0, 1, 0, 1);
        ack_mode = 0;
        tick(2); chk("tmo_release_wait", busy, 1'b1);
        tick(1); chk_all("tmo_off", 1, 0, 0, 0, 0, 0, 1);
        tick(5); chk("tmo_sticky", tmo, 1'b1);

        // On request clears timeout; zero-latency ack still needs sync time
        pulse(0, 1);
        chk_all("stale_on_sw", 0, 0, 0, 0, 1, 0, 0);
        tick(2); chk("stale_on_hold", drst_n, 1'b0);
        tick(1); chk("stale_on_rst", drst_n, 1'b1);
        tick(12); chk_all("stale_on_done", 0, 1, 1, 1, 0, 1, 0);

        // Zero-latency ack on the off path
        pulse(1, 0);
        tick(12); chk("stale_off_sw", sw_n, 1'b1);
        tick(2); chk("stale_off_hold", busy, 1'b1);
        tick(1); chk_all("stale_off", 1, 0, 0, 0, 0, 0, 0);
        pulse(0, 1);
        tick(15); chk_all("stale_back_on", 0, 1, 1, 1, 0, 1, 0);

        // Asynchronous reset in OFF_RST
        pulse(1, 0);
        tick(9); chk("pre_rst_state", drst_n, 1'b0); chk("pre_rst_iso", iso_n, 1'b0);
        rst = 1'b1;
        #1 chk_all("async_rst", 0, 1, 1, 1, 0, 1, 0);
        #1 rst = 1'b0;
        tick(2); chk_all("after_rst", 0, 1, 1, 1, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/power_domain_sequencer.md
Name: power_domain_sequencer

Overview:
- Initiator side of the power-switch handshake. Sequences one switchable domain (CPU, peripheral or external subsystem) through power-off and power-on.
- Drives clock gate, isolation, domain reset and switch request. Waits for the switch acknowledge returned by the power-switch cell, or by the testbench's delay-line emulation.
- Instantiated once per gated domain inside the power manager. Requests come from power-manager registers.

Parameters:
- STEP_CYCLES, 4, cycles held in each clock/iso/reset action state (1..255).
- ACK_TIMEOUT, 64, cycles waited for acknowledge before timeout_o asserts (>= 4).
- CNT_W, 8, width of step/timeout counter; must hold max(STEP_CYCLES, ACK_TIMEOUT).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- power_off_req_i  in  1  single-cycle pulse; request domain power-off.
- power_on_req_i  in  1  single-cycle pulse; request domain power-on.
- switch_n_o  out  1  power switch control; 0 = switch closed (domain powered).
- switch_ack_n_i  in  1  switch acknowledge, asynchronous; follows switch_n_o after unknown latency.
- clkgate_en_o  out  1  1 = domain clock enabled.
- iso_n_o  out  1  0 = domain outputs isolated.
- rst_n_o  out  1  0 = domain held in reset.
- busy_o  out  1  sequence in progress.
- domain_on_o  out  1  1 = domain in stable ON state.
- timeout_o  out  1  sticky; acknowledge not seen within ACK_TIMEOUT cycles.

Behaviour:
- Reset values: state ON; switch_n_o=0, clkgate_en_o=1, iso_n_o=1, rst_n_o=1, busy_o=0, domain_on_o=1, timeout_o=0. Counter=0. Sync flops=0.
- Acknowledge path: switch_ack_n_i passes through a 2-flop synchronizer (ack_s). Total 2-cycle latency.
- All outputs are registered Moore outputs of the state. They change on the edge that enters the new state.
- Off path:
  - ON → OFF_CLK (clkgate_en_o=0) → OFF_ISO (+iso_n_o=0) → OFF_RST (+rst_n_o=0) → OFF_SW (+switch_n_o=1) → OFF.
  - OFF_CLK, OFF_ISO and OFF_RST each last exactly STEP_CYCLES cycles.
  - OFF_SW exits on the edge after ack_s==1 is sampled.
- On path:
  - OFF → ON_SW (switch_n_o=0, others remain off) → ON_RST (rst_n_o=1) → ON_ISO (iso_n_o=1) → ON_CLK (clkgate_en_o=1) → ON.
  - ON_SW waits for ack_s==0.
  - ON_RST, ON_ISO and ON_CLK each last STEP_CYCLES cycles.
  - Reset is released before isolation is removed. The clock is enabled last.
- Counter: cleared on every state entry and incremented each cycle in a timed state. The state advances when counter==STEP_CYCLES-1.
- Off-latency: power_off_req_i at edge k → OFF_CLK at k+1 → OFF_SW entered at k+1+3*STEP_CYCLES.
- busy_o=1 in every state except ON and OFF. domain_on_o=1 only in ON.
- Acceptance:
  - power_off_req_i is honoured only in ON. power_on_req_i is honoured only in OFF.
  - Requests in any other state are dropped; there is no queueing.
  - Both pulses in the same cycle: only the one valid for the current stable state takes effect.
- Timeout:
  - In OFF_SW/ON_SW the counter runs until ACK_TIMEOUT-1 and then saturates.
  - At saturation, timeout_o is set. The FSM keeps waiting and does not abort.
  - timeout_o clears on the next accepted request. Arrival of a late ack does not clear it.
- Stale ack: on entry to OFF_SW/ON_SW the FSM must not exit within the first cycle, because ack_s still shows the previous level. Exit requires ack_s to equal the target level.
- Asynchronous rst_i mid-sequence: immediate return to reset values, i.e. domain forced ON. The system-level reset is responsible for re-powering the domain.

Decomposition:
- Package power_domain_seq_pkg holds:
  - enum pds_state_e with the 10 states (2-hot-free binary encoding);
  - a per-state output struct pds_out_t {switch_n, clkgate_en, iso_n, rst_n};
  - a function mapping state to pds_out_t.
- Sub-module: pds_ack_sync, the 2-flop synchronizer with asynchronous active-high reset to 0.
- The FSM, counter and timeout logic live in the top module.

Test Plan (STEP_CYCLES=4, ACK_TIMEOUT=64; bench responder delays switch_n_o by 15 cycles onto switch_ack_n_i):
- Power-off: off pulse at cycle 10.
  - Required: clkgate_en_o=0 at 11, iso_n_o=0 at 15, rst_n_o=0 at 19, switch_n_o=1 at 23.
  - Required: state OFF about 18 cycles later (15 latency + 2 sync + 1), busy_o=0, timeout_o=0.
- Power-on from OFF: on pulse.
  - Required: switch_n_o=0 next cycle; rst_n_o=1 after ack_s==0.
  - Required: iso_n_o=1 4 cycles later, clkgate_en_o=1 4 cycles after that, domain_on_o=1 4 cycles after that.
- Dropped requests:
  - power_on_req_i in ON → no output change.
  - power_off_req_i pulsed during OFF_ISO → ignored; sequence completes normally.
  - Both pulses in the same cycle in ON → off sequence starts.
- Timeout: responder ack tied to 0 during power-off.
  - Required: timeout_o=1 exactly 64 cycles after entering OFF_SW; FSM stays in OFF_SW.
  - Then release ack: FSM reaches OFF, timeout_o remains 1 until the next on request.
- Reset mid-sequence: assert rst_i in OFF_RST.
  - Required: within the same cycle (async) switch_n_o=0, iso_n_o=1, rst_n_o=1, clkgate_en_o=1, domain_on_o=1.
- Stale ack guard: responder latency 0 (ack equals switch_n_o).
  - Required: FSM still takes ≥2 cycles in OFF_SW; outputs keep the documented order.
